// File: rtl/rv_decode_pkg.sv
// Shared types and encodings for the RV32 decode stage.
// Opcodes, writeback/size codes, occupancy states and the decode bundle.
package rv_decode_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [1:0] RD_ALU  = 2'b00;
   localparam logic [1:0] RD_LOAD = 2'b01;
   localparam logic [1:0] RD_IMM  = 2'b10;
   localparam logic [1:0] RD_PC4  = 2'b11;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   // Register fields are kept 5 bits wide here; narrow
   // configurations truncate at the stage outputs.
   typedef struct packed {
      logic [4:0]  alu_opcode;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        imm_sel;
      logic        alu_sel;
      logic [1:0]  rd_data_sel;
      logic        reg_w;
      logic        data_w;
      logic        data_r;
      logic        unsigned_op;
      logic [1:0]  data_size;
      logic        branch;
      logic        load_pc;
      logic        illegal;
   } dec_t;

endpackage

// File: rtl/rv_decode_if.sv
// Fetch->decode->execute handshake bundle for rv_decode_stage.
// master: fetch/execute side; slave: the decode stage itself.
interface rv_decode_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int PC_W       = 32
);
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [31:0]           in_instr;
   logic [PC_W-1:0]       in_pc;
   logic                  out_valid;
   logic                  out_ready;
   logic [PC_W-1:0]       out_pc;
   logic [4:0]            out_alu_opcode;
   logic [REG_ADDR_W-1:0] out_rs1;
   logic [REG_ADDR_W-1:0] out_rs2;
   logic [REG_ADDR_W-1:0] out_rd;
   logic [XLEN-1:0]       out_imm;
   logic                  out_imm_sel;
   logic                  out_alu_sel;
   logic [1:0]            out_rd_data_sel;
   logic                  out_reg_w;
   logic                  out_data_w;
   logic                  out_data_r;
   logic                  out_unsigned;
   logic [1:0]            out_data_size;
   logic                  out_branch;
   logic                  out_load_pc;
   logic                  out_illegal;

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_alu_opcode,
      input  out_rs1, out_rs2, out_rd, out_imm,
      input  out_imm_sel, out_alu_sel, out_rd_data_sel,
      input  out_reg_w, out_data_w, out_data_r,
      input  out_unsigned, out_data_size,
      input  out_branch, out_load_pc, out_illegal
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_alu_opcode,
      output out_rs1, out_rs2, out_rd, out_imm,
      output out_imm_sel, out_alu_sel, out_rd_data_sel,
      output out_reg_w, out_data_w, out_data_r,
      output out_unsigned, out_data_size,
      output out_branch, out_load_pc, out_illegal
   );
endinterface

// File: rtl/rv_decode_comb.sv
// Combinational RV32I/E instruction decoder: instr -> dec_t bundle.
// Ports: instr (in, 32), dec (out, dec_t). Macro RV_DECODE_RV32M_EN.
module rv_decode_comb
   import rv_decode_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [31:0] instr,
   output dec_t        dec
);
   localparam bit NARROW = (REG_ADDR_W < 5);

   logic [6:0]  op;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;

   assign op  = instr[6:0];
   assign rd  = instr[11:7];
   assign f3  = instr[14:12];
   assign rs1 = instr[19:15];
   assign rs2 = instr[24:20];
   assign f7  = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25],
                   instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31],
                   instr[19:12], instr[20],
                   instr[30:21], 1'b0};

   logic is_lui, is_auipc, is_jal, is_jalr;
   logic is_branch, is_load, is_store, is_imm;
   logic is_reg, is_fence, is_system;

   assign is_lui    = (op == OP_LUI);
   assign is_auipc  = (op == OP_AUIPC);
   assign is_jal    = (op == OP_JAL);
   assign is_jalr   = (op == OP_JALR);
   assign is_branch = (op == OP_BRANCH);
   assign is_load   = (op == OP_LOAD);
   assign is_store  = (op == OP_STORE);
   assign is_imm    = (op == OP_IMM);
   assign is_reg    = (op == OP_REG);
   assign is_fence  = (op == OP_FENCE);
   assign is_system = (op == OP_SYSTEM);

   dec_t raw;
   logic bad;
   logic reg_bad;

   always_comb begin
      raw = '0;
      bad = 1'b0;
      unique case (1'b1)
         is_lui: begin
            raw.rd          = rd;
            raw.imm         = imm_u;
            raw.imm_sel     = 1'b1;
            raw.rd_data_sel = RD_IMM;
            raw.reg_w       = 1'b1;
         end
         is_auipc: begin
            raw.rd      = rd;
            raw.imm     = imm_u;
            raw.imm_sel = 1'b1;
            raw.alu_sel = 1'b1;
            raw.load_pc = 1'b1;
            raw.reg_w   = 1'b1;
         end
         is_jal: begin
            raw.rd          = rd;
            raw.imm         = imm_j;
            raw.imm_sel     = 1'b1;
            raw.alu_sel     = 1'b1;
            raw.load_pc     = 1'b1;
            raw.reg_w       = 1'b1;
            raw.rd_data_sel = RD_PC4;
         end
         is_jalr: begin
            bad             = (f3 != 3'b000);
            raw.rd          = rd;
            raw.rs1         = rs1;
            raw.imm         = imm_i;
            raw.imm_sel     = 1'b1;
            raw.alu_sel     = 1'b1;
            raw.reg_w       = 1'b1;
            raw.rd_data_sel = RD_PC4;
         end
         is_branch: begin
            // funct3 010/011 are unassigned
            bad             = (f3[2:1] == 2'b01);
            raw.rs1         = rs1;
            raw.rs2         = rs2;
            raw.imm         = imm_b;
            raw.alu_sel     = 1'b1;
            raw.branch      = 1'b1;
            raw.alu_opcode  = {2'b10, f3};
            raw.unsigned_op = f3[1];
         end
         is_load: begin
            bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            raw.rs1         = rs1;
            raw.rd          = rd;
            raw.imm         = imm_i;
            raw.imm_sel     = 1'b1;
            raw.alu_sel     = 1'b1;
            raw.data_r      = 1'b1;
            raw.reg_w       = 1'b1;
            raw.rd_data_sel = RD_LOAD;
            raw.data_size   = f3[1:0];
            raw.unsigned_op = f3[2];
         end
         is_store: begin
            bad = f3[2] || (f3[1:0] == 2'b11);
            raw.rs1       = rs1;
            raw.rs2       = rs2;
            raw.imm       = imm_s;
            raw.imm_sel   = 1'b1;
            raw.alu_sel   = 1'b1;
            raw.data_w    = 1'b1;
            raw.data_size = f3[1:0];
         end
         is_imm: begin
            raw.rs1     = rs1;
            raw.rd      = rd;
            raw.imm_sel = 1'b1;
            raw.alu_sel = 1'b1;
            raw.reg_w   = 1'b1;
            if (f3 == 3'b001) begin
               bad            = (f7 != F7_BASE);
               raw.imm        = {27'b0, instr[24:20]};
               raw.alu_opcode = {f7[6:5], f3};
            end else if (f3 == 3'b101) begin
               bad = (f7 != F7_BASE) && (f7 != F7_ALT);
               raw.imm        = {27'b0, instr[24:20]};
               raw.alu_opcode = {f7[6:5], f3};
            end else begin
               raw.imm         = imm_i;
               raw.alu_opcode  = {2'b00, f3};
               raw.unsigned_op = (f3 == 3'b011);
            end
         end
         is_reg: begin
            raw.rs1         = rs1;
            raw.rs2         = rs2;
            raw.rd          = rd;
            raw.alu_sel     = 1'b1;
            raw.reg_w       = 1'b1;
            raw.alu_opcode  = {f7[6:5], f3};
            raw.unsigned_op = (f3 == 3'b011);
            if (f7 == F7_ALT) begin
               bad = (f3 != 3'b000) && (f3 != 3'b101);
            end else if (f7 == F7_MULDIV) begin
`ifdef RV_DECODE_RV32M_EN
               raw.alu_opcode  = {2'b11, f3};
               raw.unsigned_op = 1'b0;
`else
               bad = 1'b1;
`endif
            end else if (f7 != F7_BASE) begin
               bad = 1'b1;
            end
         end
         is_fence: begin
            bad = (f3 != 3'b000);
         end
         is_system: begin
            bad = 1'b1;
         end
         default: begin
            bad = 1'b1;
         end
      endcase
   end

   // Unused fields are already zero, so only real
   // register references can trip the narrow check.
   assign reg_bad = NARROW &&
                    (raw.rs1[4] | raw.rs2[4] | raw.rd[4]);

   always_comb begin
      dec = raw;
      if (bad || reg_bad) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
   end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage with 2-entry skid buffer, flush, illegal flag.
// Ports: clk, reset_n (sync, low), bus (rv_decode_if.slave). Macro RV_DECODE_RV32M_EN.
module rv_decode_stage
   import rv_decode_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int PC_W       = 32
) (
   input logic       clk,
   input logic       reset_n,
   rv_decode_if.slave bus
);
   if (XLEN != 32) begin : g_xlen_chk
      $error("rv_decode_stage: XLEN must be 32");
   end
   if (REG_ADDR_W != 4 && REG_ADDR_W != 5) begin : g_reg_chk
      $error("rv_decode_stage: REG_ADDR_W must be 4 or 5");
   end

   dec_t            new_dec;
   dec_t            head_dec;
   dec_t            tail_dec;
   logic [PC_W-1:0] head_pc;
   logic [PC_W-1:0] tail_pc;

   occ_e state;
   occ_e nstate;
   logic in_rdy;
   logic out_vld;
   logic push;
   logic pop;
   logic ld_head_new;
   logic ld_head_tail;
   logic ld_tail;

   rv_decode_comb #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_comb (
      .instr (bus.in_instr),
      .dec   (new_dec)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= OCC_EMPTY;
      end else begin
         state <= nstate;
      end
   end

   always_comb begin
      nstate = state;
      if (bus.flush) begin
         nstate = OCC_EMPTY;
      end else begin
         unique case (state)
            OCC_EMPTY: if (push) nstate = OCC_ONE;
            OCC_ONE: begin
               if (push && !pop) nstate = OCC_TWO;
               else if (pop && !push) nstate = OCC_EMPTY;
            end
            OCC_TWO: if (pop) nstate = OCC_ONE;
            default: nstate = OCC_EMPTY;
         endcase
      end
   end

   // Flags depend only on the state register, so in_ready
   // has no combinational path from out_ready.
   always_comb begin
      in_rdy  = (state != OCC_TWO);
      out_vld = (state != OCC_EMPTY);
      push    = bus.in_valid && in_rdy && !bus.flush;
      pop     = out_vld && bus.out_ready;
      ld_head_new = push &&
                    ((state == OCC_EMPTY) ||
                     (state == OCC_ONE && pop));
      ld_head_tail = pop && (state == OCC_TWO);
      ld_tail      = push && (state == OCC_ONE) && !pop;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head_dec <= '0;
         head_pc  <= '0;
         tail_dec <= '0;
         tail_pc  <= '0;
      end else begin
         if (ld_head_new) begin
            head_dec <= new_dec;
            head_pc  <= bus.in_pc;
         end else if (ld_head_tail) begin
            head_dec <= tail_dec;
            head_pc  <= tail_pc;
         end
         if (ld_tail) begin
            tail_dec <= new_dec;
            tail_pc  <= bus.in_pc;
         end
      end
   end

   assign bus.in_ready        = in_rdy;
   assign bus.out_valid       = out_vld;
   assign bus.out_pc          = head_pc;
   assign bus.out_alu_opcode  = head_dec.alu_opcode;
   assign bus.out_rs1         = head_dec.rs1[REG_ADDR_W-1:0];
   assign bus.out_rs2         = head_dec.rs2[REG_ADDR_W-1:0];
   assign bus.out_rd          = head_dec.rd[REG_ADDR_W-1:0];
   assign bus.out_imm         = head_dec.imm;
   assign bus.out_imm_sel     = head_dec.imm_sel;
   assign bus.out_alu_sel     = head_dec.alu_sel;
   assign bus.out_rd_data_sel = head_dec.rd_data_sel;
   assign bus.out_reg_w       = head_dec.reg_w;
   assign bus.out_data_w      = head_dec.data_w;
   assign bus.out_data_r      = head_dec.data_r;
   assign bus.out_unsigned    = head_dec.unsigned_op;
   assign bus.out_data_size   = head_dec.data_size;
   assign bus.out_branch      = head_dec.branch;
   assign bus.out_load_pc     = head_dec.load_pc;
   assign bus.out_illegal     = head_dec.illegal;

endmodule
